hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer between the datapath and the combinational multiply/divide units.
- Latches operands, holds them stable on the unit inputs for a fixed number of cycles so the long combinational paths settle, then captures the results into the architectural HI/LO registers (MFHI/MFLO source).
- Also services direct MTHI/MTLO writes, and gives the control unit a busy/done handshake for stalling.

Parameters:
LATENCY, 4, clock cycles from start acceptance to HI/LO capture; legal range 1..15.

Ports:
clock  in  1  system clock, all state updates on rising edge
clear_n  in  1  synchronous active-low reset
start  in  1  request an operation; sampled only in IDLE
op  in  1  0 = multiply, 1 = divide
a_in  in  32  dividend / multiplicand (signed)
b_in  in  32  divisor / multiplier (signed)
div_a  out  32  latched dividend to divider
div_b  out  32  latched divisor to divider
div_q  in  32  divider quotient
div_r  in  32  divider remainder
mul_a  out  32  latched multiplicand to multiplier
mul_b  out  32  latched multiplier to multiplier
mul_p  in  64  multiplier product (signed)
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
hi_in  in  32  MTHI data
lo_in  in  32  MTLO data
hi_out  out  32  HI register
lo_out  out  32  LO register
busy  out  1  operation in progress; control unit stalls
done  out  1  one-cycle pulse: HI/LO hold new result
div_zero  out  1  last divide had b = 0; sticky until next accepted start

Behaviour:
- Reset: edge with clear_n = 0 forces state IDLE, counter 0, operand regs 0, HI/LO 0, busy/done/div_zero 0. Applies mid-operation: in-flight op abandoned, no HI/LO write.
- Operand outputs:
  - div_a/mul_a = latched A; div_b/mul_b = latched B.
  - Outputs are registered and change only on an accepted start.
- States: IDLE, RUN.
- IDLE:
  - start = 1 at edge: latch a_in, b_in, op.
  - Load counter = LATENCY-1.
  - Clear div_zero.
  - Go to RUN.
  - busy = 1 from the next cycle.
- RUN:
  - Counter decrements each edge.
  - At the edge where counter = 0: capture results and return to IDLE. busy drops and done = 1 for exactly the following cycle.
  - Start-to-done latency is LATENCY cycles. Back-to-back start is accepted in the done cycle.
- Capture, divide, b latched != 0: LO <= div_q, HI <= div_r. Values are taken exactly as produced; no sign fix-up here.
- Capture, divide, b latched = 0: LO <= 32'hFFFF_FFFF, HI <= latched A, div_zero <= 1. Same latency; divider outputs ignored.
- Capture, multiply: HI <= mul_p[63:32], LO <= mul_p[31:0].
- Ignored inputs:
  - start while busy is ignored; no queueing.
  - op/a_in/b_in changes after acceptance have no effect.
- MTHI/MTLO:
  - Honoured only in IDLE.
  - While busy, hi_we/lo_we are ignored and HI/LO are unchanged until capture.
- Simultaneous events in IDLE:
  - hi_we/lo_we and start together: the MT write takes effect at that edge and the operation proceeds.
  - The later capture overwrites both registers.
- done never asserts without a preceding accepted start. div_zero is unchanged by MT writes.

Test Plan:
- Reset mid-op: LATENCY=4; start mul, assert clear_n=0 on cycle 2 -> busy=0, done never pulses, HI=LO=0.
- Multiply: a=0x0001_0000, b=0x0001_0000, mul_p=64'h1_0000_0000 -> busy for 4 cycles, done pulse on cycle 5, HI=1, LO=0.
- Divide: a=7, b=-2, divider returns q=-3, r=1 -> LO=0xFFFF_FFFD, HI=1, div_zero=0.
- Divide by zero: a=0x1234, b=0 -> LO=0xFFFF_FFFF, HI=0x1234, div_zero=1. A following multiply start clears div_zero.
- Ignored requests while busy: start (a=5, b=5) and hi_we=1 with hi_in=0xDEAD mid-divide -> HI/LO equal the first op's result; no second done.
- Back-to-back and simultaneous events: start in the done cycle -> accepted, busy=1 next cycle. start+lo_we (lo_in=9) in IDLE -> LO=9 after one edge, then overwritten at capture.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_ctrl
// Purpose  : Multi-cycle sequencer for the combinational mul/div units, owning
//            the architectural HI/LO registers and the MTHI/MTLO write path.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl #(
  parameter int LATENCY = 4
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_p,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [0:0]  state;
  logic [3:0]  count;
  logic [31:0] a_lat;
  logic [31:0] b_lat;
  logic        op_lat;

  assign div_a = a_lat;
  assign div_b = b_lat;
  assign mul_a = a_lat;
  assign mul_b = b_lat;
  assign busy  = (state == RUN);

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state    <= IDLE;
      count    <= 4'd0;
      a_lat    <= 32'd0;
      b_lat    <= 32'd0;
      op_lat   <= 1'b0;
      hi_out   <= 32'd0;
      lo_out   <= 32'd0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        // MT writes land on the same edge as an accepted start; the later
        // capture overwrites them.
        if (hi_we) hi_out <= hi_in;
        if (lo_we) lo_out <= lo_in;
        if (start) begin
          a_lat    <= a_in;
          b_lat    <= b_in;
          op_lat   <= op;
          count    <= CNT_INIT;
          div_zero <= 1'b0;
          state    <= RUN;
        end
      end else begin
        if (count == 4'd0) begin
          state <= IDLE;
          done  <= 1'b1;
          if (!op_lat) begin
            hi_out <= mul_p[63:32];
            lo_out <= mul_p[31:0];
          end else if (b_lat == 32'd0) begin
            hi_out   <= a_lat;
            lo_out   <= 32'hFFFF_FFFF;
            div_zero <= 1'b1;
          end else begin
            hi_out <= div_r;
            lo_out <= div_q;
          end
        end else begin
          count <= count - 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// Directed bench for hilo_muldiv_ctrl (LATENCY = 4); the bench plays the
// mul/div units by driving mul_p / div_q / div_r with hand-computed values.
module tb_hilo_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        start;
  logic        op;
  logic [31:0] a_in, b_in;
  logic [31:0] div_a, div_b, div_q, div_r;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_p;
  logic        hi_we, lo_we;
  logic [31:0] hi_in, lo_in;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero;

  int tests_run = 0;
  int tests_failed = 0;
  int done_seen;

  hilo_muldiv_ctrl #(.LATENCY(4)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .start   (start),
    .op      (op),
    .a_in    (a_in),
    .b_in    (b_in),
    .div_a   (div_a),
    .div_b   (div_b),
    .div_q   (div_q),
    .div_r   (div_r),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_p   (mul_p),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .hi_in   (hi_in),
    .lo_in   (lo_in),
    .hi_out  (hi_out),
    .lo_out  (lo_out),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_n = 1'b0; start = 1'b0; op = 1'b0;
    a_in = '0; b_in = '0; div_q = '0; div_r = '0; mul_p = '0;
    hi_we = 1'b0; lo_we = 1'b0; hi_in = '0; lo_in = '0;
    tick(); tick();
    clear_n = 1'b1;

    // reset state
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_hi", hi_out, 0);
    check_eq("rst_lo", lo_out, 0);
    check_eq("rst_dz", div_zero, 0);
    check_eq("rst_diva", div_a, 0);

    // reset mid-operation
    op = 1'b0; a_in = 32'd3; b_in = 32'd4; mul_p = 64'd12; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("mid_busy1", busy, 1);
    check_eq("mid_mula", mul_a, 3);
    tick();
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    check_eq("mid_busy0", busy, 0);
    check_eq("mid_mula0", mul_a, 0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_seen++;
      tick();
    end
    check_eq("mid_nodone", done_seen, 0);
    check_eq("mid_hi", hi_out, 0);
    check_eq("mid_lo", lo_out, 0);

    // multiply 0x10000 * 0x10000
    op = 1'b0; a_in = 32'h0001_0000; b_in = 32'h0001_0000;
    mul_p = 64'h1_0000_0000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("mul_busy", busy, 1);
      check_eq("mul_nodone", done, 0);
      tick();
    end
    check_eq("mul_busy_drop", busy, 0);
    check_eq("mul_done", done, 1);
    check_eq("mul_hi", hi_out, 1);
    check_eq("mul_lo", lo_out, 0);
    tick();
    check_eq("mul_done_pulse", done, 0);

    // divide 7 / -2 -> q=-3 r=1
    op = 1'b1; a_in = 32'd7; b_in = 32'hFFFF_FFFE;
    div_q = 32'hFFFF_FFFD; div_r = 32'd1; start = 1'b1;
    tick();
    start = 1'b0; a_in = 32'd99; b_in = 32'd0; op = 1'b0;
    check_eq("div_a_lat", div_a, 7);
    check_eq("div_b_lat", div_b, 32'hFFFF_FFFE);
    tick(); tick(); tick(); tick();
    check_eq("div_done", done, 1);
    check_eq("div_lo", lo_out, 32'hFFFF_FFFD);
    check_eq("div_hi", hi_out, 1);
    check_eq("div_dz", div_zero, 0);

    // divide by zero
    op = 1'b1; a_in = 32'h1234; b_in = 32'd0;
    div_q = 32'h55; div_r = 32'h66; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("dz_done", done, 1);
    check_eq("dz_lo", lo_out, 32'hFFFF_FFFF);
    check_eq("dz_hi", hi_out, 32'h1234);
    check_eq("dz_flag", div_zero, 1);
    hi_we = 1'b1; hi_in = 32'hABCD;
    tick();
    hi_we = 1'b0;
    check_eq("mthi_hi", hi_out, 32'hABCD);
    check_eq("mthi_dz_kept", div_zero, 1);
    op = 1'b0; a_in = 32'd2; b_in = 32'd3; mul_p = 64'd6; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("dz_cleared", div_zero, 0);
    tick(); tick(); tick(); tick();
    check_eq("mul2_lo", lo_out, 6);
    check_eq("mul2_hi", hi_out, 0);

    // requests while busy are ignored: 20 / 3 -> q=6 r=2
    op = 1'b1; a_in = 32'd20; b_in = 32'd3; div_q = 32'd6; div_r = 32'd2; start = 1'b1;
    tick();
    a_in = 32'd5; b_in = 32'd5; hi_we = 1'b1; hi_in = 32'hDEAD;
    tick();
    start = 1'b0; hi_we = 1'b0;
    check_eq("busy_hi_kept", hi_out, 0);
    check_eq("busy_diva_kept", div_a, 20);
    tick(); tick(); tick();
    check_eq("ign_done", done, 1);
    check_eq("ign_lo", lo_out, 6);
    check_eq("ign_hi", hi_out, 2);
    done_seen = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (done) done_seen++;
      tick();
    end
    check_eq("ign_no_second_done", done_seen, 0);

    // back-to-back start in done cycle, combined with MTLO
    op = 1'b0; a_in = 32'd1; b_in = 32'd1; mul_p = 64'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("b2b_done", done, 1);
    check_eq("b2b_lo1", lo_out, 1);
    op = 1'b1; a_in = 32'd9; b_in = 32'd2; div_q = 32'd4; div_r = 32'd1;
    start = 1'b1; lo_we = 1'b1; lo_in = 32'd9;
    tick();
    start = 1'b0; lo_we = 1'b0;
    check_eq("b2b_busy", busy, 1);
    check_eq("b2b_mtlo", lo_out, 9);
    check_eq("b2b_diva", div_a, 9);
    tick(); tick(); tick(); tick();
    check_eq("b2b_done2", done, 1);
    check_eq("b2b_lo2", lo_out, 4);
    check_eq("b2b_hi2", hi_out, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
